// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one registered ALU among NUM_REQ requesters. Round-robin
//            arbitration by default; define ALU_ARB_FIXED_PRIO_EN for fixed
//            lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int N       = 12,
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [3*NUM_REQ-1:0]   req_op_i,
  input  logic [N*NUM_REQ-1:0]   req_a_i,
  input  logic [N*NUM_REQ-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [N-1:0]           rsp_data_o,
  output logic                   rsp_z_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic [2:0]             alu_op_o,
  output logic [N-1:0]           alu_in1_o,
  output logic [N-1:0]           alu_in2_o,
  input  logic [N-1:0]           alu_out_i,
  input  logic [15:0]            alu_z_i
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ZCAP = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      win_q;
  logic               err_q;
  logic [NUM_REQ-1:0] gnt_q, rsp_valid_q;
  logic [N-1:0]       rsp_data_q;
  logic               rsp_z_q, rsp_err_q;
  logic [2:0]         alu_op_q;
  logic [N-1:0]       alu_in1_q, alu_in2_q;

  logic [IW-1:0]      start;
  logic [IW-1:0]      pick;
  logic               found;
  logic [2:0]         sel_op;
  logic [N-1:0]       sel_a, sel_b;
  logic               op_legal;
  logic               unused_z;

  assign unused_z = ^alu_z_i[15:1];

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Searching from the last index makes index 0 the first candidate every time.
  assign start = IW'(NUM_REQ - 1);
`else
  logic [IW-1:0] ptr_q;

  assign start = ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IW'(NUM_REQ - 1);
    end else if (state_q == S_IDLE && found) begin
      ptr_q <= pick;
    end
  end
`endif

  // Cyclic search starting one past the pointer; first requester found wins.
  always_comb begin : arb_search
    logic [IW-1:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == IW'(NUM_REQ - 1)) cand = '0;
      else                          cand = cand + 1'b1;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IW'(i)) begin
        sel_op = req_op_i[3*i +: 3];
        sel_a  = req_a_i[N*i +: N];
        sel_b  = req_b_i[N*i +: N];
      end
    end
  end

  assign op_legal = (sel_op >= 3'd1) && (sel_op <= 3'd4);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_EXEC;
      S_EXEC:  state_d = S_HOLD;
      S_HOLD:  state_d = S_ZCAP;
      S_ZCAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      err_q       <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_z_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      alu_op_q    <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            gnt_q     <= NUM_REQ'(1) << pick;
            win_q     <= pick;
            err_q     <= !op_legal;
            alu_op_q  <= op_legal ? sel_op : 3'd0;
            alu_in1_q <= sel_a;
            alu_in2_q <= sel_b;
          end
        end
        S_EXEC: alu_op_q <= 3'd0;
        S_ZCAP: begin
          // Illegal ops never reached the ALU, so its outputs are stale here.
          rsp_valid_q <= NUM_REQ'(1) << win_q;
          rsp_data_q  <= err_q ? '0 : alu_out_i;
          rsp_z_q     <= err_q ? 1'b0 : alu_z_i[0];
          rsp_err_q   <= err_q;
        end
        default: ;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_z_o     = rsp_z_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign alu_op_o    = alu_op_q;
  assign alu_in1_o   = alu_in1_q;
  assign alu_in2_o   = alu_in2_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter with a behavioural registered ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam int N  = 12;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [3*NR-1:0] req_op;
  logic [N*NR-1:0] req_a, req_b;
  logic [NR-1:0]   gnt, rsp_valid;
  logic [N-1:0]    rsp_data;
  logic            rsp_z, rsp_err, busy;
  logic [2:0]      alu_op;
  logic [N-1:0]    alu_in1, alu_in2;
  logic [N-1:0]    alu_out = '0;
  logic [15:0]     alu_z   = '0;

  typedef struct packed {
    logic [NR-1:0] who;
    logic [N-1:0]  data;
    logic          z;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_z_o(rsp_z), .rsp_err_o(rsp_err), .busy_o(busy),
    .alu_op_o(alu_op), .alu_in1_o(alu_in1), .alu_in2_o(alu_in2),
    .alu_out_i(alu_out), .alu_z_i(alu_z)
  );

  // Registered ALU: result on the edge after the op, zero flag one edge later.
  always @(posedge clk) begin
    case (alu_op)
      3'd1: alu_out <= alu_in1 + alu_in2;
      3'd2: alu_out <= alu_in1 - alu_in2;
      3'd3: alu_out <= alu_in1 * alu_in2;
      3'd4: alu_out <= alu_in1 << alu_in2;
      default: ;
    endcase
    alu_z <= {15'b0, alu_out == '0};
  end

  function automatic exp_t model(int idx, logic [2:0] op, logic [N-1:0] a, logic [N-1:0] b);
    exp_t e;
    logic [2*N-1:0] p;
    e.who = NR'(1) << idx;
    e.err = 1'b0;
    p     = '0;
    case (op)
      3'd1: e.data = a + b;
      3'd2: e.data = a - b;
      3'd3: begin p = a * b; e.data = p[N-1:0]; end
      3'd4: e.data = a << b;
      default: begin e.data = '0; e.err = 1'b1; end
    endcase
    e.z = !e.err && (e.data == '0);
    return e;
  endfunction

  task automatic set_payload(int idx, logic [2:0] op, logic [N-1:0] a, logic [N-1:0] b);
    req_op[3*idx +: 3] = op;
    req_a[N*idx +: N]  = a;
    req_b[N*idx +: N]  = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_op = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gnt, rsp_valid, rsp_data, rsp_z, rsp_err, busy, alu_op, alu_in1, alu_in2} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: gnt=%b vld=%b data=%h z=%b err=%b busy=%b op=%0d in1=%h in2=%h, required all 0",
               gnt, rsp_valid, rsp_data, rsp_z, rsp_err, busy, alu_op, alu_in1, alu_in2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    int          idx_t[6] = '{0, 2, 3, 1, 0, 2};
    logic [2:0]  op_t[6]  = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd2};
    logic [N-1:0] a_t[6]  = '{12'd5, 12'd9, 12'hFFF, 12'h040, 12'd3, 12'd3};
    logic [N-1:0] b_t[6]  = '{12'd7, 12'd9, 12'd1, 12'h040, 12'd2, 12'd5};
    for (int c = 0; c < 6; c++) begin
      int   lat;
      logic got;
      exp_t e;
      set_payload(idx_t[c], op_t[c], a_t[c], b_t[c]);
      req = NR'(1) << idx_t[c];
      sb.push_back(model(idx_t[c], op_t[c], a_t[c], b_t[c]));
      @(negedge clk);
      n_cmp++;
      if (gnt !== (NR'(1) << idx_t[c]) || alu_op !== op_t[c] || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL arith%0d_grant: gnt=%b op=%0d busy=%b, required gnt=%b op=%0d busy=1",
                 c, gnt, alu_op, busy, NR'(1) << idx_t[c], op_t[c]);
      end
      req = '0;
      lat = 1; got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        if (rsp_valid != '0) got = 1'b1;
      end
      n_cmp++;
      if (!got || lat != 4) begin
        n_bad++;
        $display("FAIL arith%0d_latency: got=%b cycle=%0d, required response in cycle 4", c, got, lat);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_z, rsp_err} !== {e.who, e.data, e.z, e.err}) begin
          n_bad++;
          $display("FAIL arith%0d_rsp: vld=%b data=%h z=%b err=%b, required vld=%b data=%h z=%b err=%b",
                   c, rsp_valid, rsp_data, rsp_z, rsp_err, e.who, e.data, e.z, e.err);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] op_t[3] = '{3'd6, 3'd0, 3'd7};
    for (int c = 0; c < 3; c++) begin
      int   lat;
      logic got, leak;
      exp_t e;
      set_payload(1, op_t[c], 12'd4, 12'd4);
      req = 4'b0010;
      sb.push_back(model(1, op_t[c], 12'd4, 12'd4));
      @(negedge clk);
      n_cmp++;
      if (gnt !== 4'b0010) begin
        n_bad++;
        $display("FAIL illegal%0d_grant: gnt=%b, required 0010", c, gnt);
      end
      req = '0;
      leak = (alu_op != 3'd0);
      lat = 1; got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        if (alu_op != 3'd0) leak = 1'b1;
        if (rsp_valid != '0) got = 1'b1;
      end
      n_cmp++;
      if (leak || !got) begin
        n_bad++;
        $display("FAIL illegal%0d_aluop: op_seen=%b got=%b, required op 0 and a response", c, leak, got);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_z, rsp_err} !== {e.who, e.data, e.z, e.err}) begin
          n_bad++;
          $display("FAIL illegal%0d_rsp: vld=%b data=%h z=%b err=%b, required vld=%b data=%h z=%b err=%b",
                   c, rsp_valid, rsp_data, rsp_z, rsp_err, e.who, e.data, e.z, e.err);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    set_payload(1, 3'd1, 12'd3, 12'd4);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_busy: busy=%b, required 1 in hold", busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt, rsp_valid, rsp_data, rsp_z, rsp_err, busy, alu_op, alu_in1, alu_in2} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: gnt=%b vld=%b data=%h busy=%b op=%0d in1=%h in2=%h, required all 0",
               gnt, rsp_valid, rsp_data, busy, alu_op, alu_in1, alu_in2);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != '0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL rstmid_norsp: rsp_valid seen=%b, required none", seen);
    end
  endtask

  task automatic test_round_robin();
    int ng = 0, last = 0, cyc = 0, exp_idx, gi;
    exp_t e;
    for (int i = 0; i < NR; i++) set_payload(i, 3'd1, N'(i + 1), N'(10 * i));
    req = '1;
    while ((ng < 5 || sb.size() > 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_idx = 0;
`else
        exp_idx = ng % NR;
`endif
        gi = -1;
        for (int i = 0; i < NR; i++) if (gnt[i]) gi = i;
        n_cmp++;
        if (gnt !== (NR'(1) << exp_idx)) begin
          n_bad++;
          $display("FAIL rr_grant%0d: gnt=%b, required %b", ng, gnt, NR'(1) << exp_idx);
        end
        if (ng > 0) begin
          n_cmp++;
          if (cyc - last != 4) begin
            n_bad++;
            $display("FAIL rr_spacing%0d: %0d cycles, required 4", ng, cyc - last);
          end
        end
        if (gi >= 0) sb.push_back(model(gi, 3'd1, N'(gi + 1), N'(10 * gi)));
        last = cyc;
        ng++;
        if (ng == 5) req = '0;
      end
      if (rsp_valid != '0 && sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_z, rsp_err} !== {e.who, e.data, e.z, e.err}) begin
          n_bad++;
          $display("FAIL rr_rsp: vld=%b data=%h z=%b err=%b, required vld=%b data=%h z=%b err=%b",
                   rsp_valid, rsp_data, rsp_z, rsp_err, e.who, e.data, e.z, e.err);
        end
      end
    end
    n_cmp++;
    if (ng != 5 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL rr_timeout: grants=%0d pending=%0d, required 5 grants and none pending", ng, sb.size());
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_illegal();
    test_reset_mid();
    test_round_robin();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
